fwd_bypass_net: RTL and testbench
=================================

// Module: fwd_bypass_net
// PURPOSE
//  Parametrised operand-bypass network with a built-in hazard scoreboard for the decode stage.
//  Tracks the destination register and result of every in-flight instruction in stages 1..DEPTH
//  (EX, MEM, WB for DEPTH=3). Returns the youngest value for NRD read ports and raises stall when
//  that value is not yet produced.
//  Replaces the fixed per-operand forwarding muxes and the external select decode.
// PARAMETERS
//  W      32  datapath width
//  NRD    2   number of decode read ports (rs, rt, ...)
//  DEPTH  3   tracked stages after decode; stage DEPTH = writeback
//  AW     5   register address width; address 0 is hardwired zero
// PORTS
//  clk          in   1           rising-edge clock
//  rst_n        in   1           asynchronous active-low reset
//  iss_valid    in   1           decode issues an instruction this cycle
//  iss_wen      in   1           issued instruction writes a register
//  iss_waddr    in   AW          its destination register
//  st_wvalid    in   DEPTH       bit k-1: stage k produces its result this cycle
//  st_wdata     in   DEPTH*W     slice k-1: stage k result data
//  flush        in   1           kill all tracked instructions (exception/redirect)
//  rd_addr      in   NRD*AW      per-port source register
//  rd_regfile   in   NRD*W       per-port register-file read data
//  rd_data      out  NRD*W       per-port bypassed operand
//  rd_src       out  NRD*2+...   per-port source: 0 = regfile, k = stage k ($clog2(DEPTH+1) bits each)
//  stall        out  1           decode must hold; any port's youngest producer not ready
// BEHAVIOUR
//  State: entry[k], k=1..DEPTH: valid, addr[AW], rdy, data[W]. Reset: all valid=0, rdy=0, addr=0, data=0.
//  Outputs are combinational from state and inputs. rd_data equals rd_regfile and rd_src=0 while
//  in reset; stall=0.
//  Effective readiness: eff_rdy[k] = rdy[k] | st_wvalid[k-1]; eff_data[k] = st_wvalid[k-1] ? st_wdata slice : data[k].
//  Lookup per port p: match[k] = valid[k] & addr[k]==rd_addr[p] & rd_addr[p]!=0.
//  Lowest k (youngest) with match wins. Hit & eff_rdy -> rd_data=eff_data[k], rd_src=k.
//  Hit & !eff_rdy -> port hazard; rd_data=rd_regfile, rd_src=k.
//  No hit -> rd_data=rd_regfile, rd_src=0.
//  stall = OR of port hazards. Ports are independent; same address on two ports gives identical results.
//  Per clock edge (no flush): entry[k+1] <= {valid[k], addr[k], eff_rdy[k], eff_data[k]} for k<DEPTH.
//  Entry[DEPTH] contents leave; the regfile commits them on that edge.
//  Entry[1] <= valid = iss_valid & iss_wen & !stall & iss_waddr!=0; addr=iss_waddr; rdy=0; data=0.
//  A stalled issue inserts a bubble (valid=0) into stage 1; older stages always advance.
//  The stall is therefore released no later than when the producer reaches a stage whose st_wvalid fires.
//  Writes to register 0 are never tracked.
//  Once an entry is rdy, its data is frozen while it shifts; later st_wvalid on that stage is ignored.
//  flush: on the edge, all valid<=0 and rdy<=0, including stage-1 issue of the same cycle.
//  During the flush cycle, lookups still use pre-flush state.
//  Reset mid-operation: all state clears asynchronously on rst_n low. The first post-reset cycle sees an empty scoreboard.
//  Latency: bypass result same cycle; a result produced in stage k at cycle t is visible from stage k+1 at t+1.
// TESTING
//  1) Reset, rd_addr={8,9}, rd_regfile={A,B}, no issues -> rd_data={A,B}, rd_src={0,0}, stall=0.
//  2) Issue waddr=8; next cycle st_wvalid[0]=1, st_wdata=0x1234, rd_addr[0]=8 -> rd_data=0x1234, rd_src=1, stall=0.
//  3) Load-use: issue waddr=8, st_wvalid=0 at stage 1. Next cycle read 8 -> stall=1.
//     Stage 2 then produces 0x55 -> stall=0, rd_data=0x55, rd_src=2.
//  4) Two in-flight writers of reg 8 in stages 1 (0xAA, ready) and 3 (0xBB) -> rd_data=0xAA, rd_src=1 (youngest wins).
//  5) Issue waddr=0 then read reg 0 -> rd_src=0, rd_data=rd_regfile, stall=0.
//  6) Pending hazard on reg 8, assert flush -> next cycle stall=0, rd_src=0.
//     Assert rst_n=0 mid-stall -> stall=0 immediately.

Source files
------------

// File: rtl/fwd_bypass_net.sv
// Decode-stage operand bypass network with an in-flight hazard scoreboard.
// Each tracked stage holds {valid, addr, rdy, data}; read ports pick the youngest matching producer.
module fwd_bypass_net #(
  parameter int unsigned W     = 32,
  parameter int unsigned NRD   = 2,
  parameter int unsigned DEPTH = 3,
  parameter int unsigned AW    = 5
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             iss_valid,
  input  logic                             iss_wen,
  input  logic [AW-1:0]                    iss_waddr,
  input  logic [DEPTH-1:0]                 st_wvalid,
  input  logic [DEPTH*W-1:0]               st_wdata,
  input  logic                             flush,
  input  logic [NRD*AW-1:0]                rd_addr,
  input  logic [NRD*W-1:0]                 rd_regfile,
  output logic [NRD*W-1:0]                 rd_data,
  output logic [NRD*$clog2(DEPTH+1)-1:0]   rd_src,
  output logic                             stall
);

  localparam int unsigned SW = $clog2(DEPTH + 1);

  // Index i holds stage i+1; index 0 is the youngest (EX).
  logic [DEPTH-1:0]         valid_q;
  logic [DEPTH-1:0]         rdy_q;
  logic [DEPTH-1:0][AW-1:0] addr_q;
  logic [DEPTH-1:0][W-1:0]  data_q;

  logic [DEPTH-1:0]         eff_rdy;
  logic [DEPTH-1:0][W-1:0]  eff_data;
  logic [NRD-1:0]           hazard;
  logic [AW-1:0]            raddr;
  logic                     hit;

  // A ready entry keeps its captured value; a late write strobe on that stage is ignored.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      eff_rdy[i]  = rdy_q[i] | st_wvalid[i];
      eff_data[i] = (st_wvalid[i] && !rdy_q[i]) ? st_wdata[i*W +: W] : data_q[i];
    end
  end

  always_comb begin
    hazard  = '0;
    rd_data = rd_regfile;
    rd_src  = '0;
    raddr   = '0;
    hit     = 1'b0;
    for (int p = 0; p < NRD; p++) begin
      raddr = rd_addr[p*AW +: AW];
      hit   = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        if (!hit && valid_q[i] && (addr_q[i] == raddr) && (raddr != '0)) begin
          hit                = 1'b1;
          rd_src[p*SW +: SW] = SW'(i + 1);
          if (eff_rdy[i]) begin
            rd_data[p*W +: W] = eff_data[i];
          end else begin
            hazard[p] = 1'b1;
          end
        end
      end
    end
  end

  assign stall = |hazard;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      rdy_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1] & ~flush;
        rdy_q[i]   <= eff_rdy[i-1] & ~flush;
        addr_q[i]  <= addr_q[i-1];
        data_q[i]  <= eff_data[i-1];
      end
      // A stalled issue becomes a bubble; register 0 is never tracked.
      valid_q[0] <= iss_valid & iss_wen & ~stall & (iss_waddr != '0) & ~flush;
      rdy_q[0]   <= 1'b0;
      addr_q[0]  <= iss_waddr;
      data_q[0]  <= '0;
    end
  end

endmodule

// File: tb/tb_fwd_bypass_net.sv
// Directed bench for fwd_bypass_net: forwarding, load-use stalls, youngest-wins, r0, flush, reset.
module tb_fwd_bypass_net;

  localparam int unsigned W = 32, NRD = 2, DEPTH = 3, AW = 5;
  localparam logic [31:0] RF_A = 32'hA0A0_A0A0, RF_B = 32'hB0B0_B0B0;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 iss_valid, iss_wen, flush;
  logic [AW-1:0]        iss_waddr;
  logic [DEPTH-1:0]     st_wvalid;
  logic [DEPTH*W-1:0]   st_wdata;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*W-1:0]     rd_regfile;
  logic [NRD*W-1:0]     rd_data;
  logic [NRD*2-1:0]     rd_src;
  logic                 stall;

  int tests = 0;
  int fails = 0;

  fwd_bypass_net #(.W(W), .NRD(NRD), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .iss_valid  (iss_valid),
    .iss_wen    (iss_wen),
    .iss_waddr  (iss_waddr),
    .st_wvalid  (st_wvalid),
    .st_wdata   (st_wdata),
    .flush      (flush),
    .rd_addr    (rd_addr),
    .rd_regfile (rd_regfile),
    .rd_data    (rd_data),
    .rd_src     (rd_src),
    .stall      (stall)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge and return inputs to idle.
  task automatic step();
    @(posedge clk);
    #1;
    iss_valid = 1'b0;
    iss_wen   = 1'b0;
    iss_waddr = '0;
    st_wvalid = '0;
    st_wdata  = '0;
    flush     = 1'b0;
  endtask

  task automatic issue(input logic [AW-1:0] a);
    iss_valid = 1'b1;
    iss_wen   = 1'b1;
    iss_waddr = a;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    iss_valid = 1'b0; iss_wen = 1'b0; iss_waddr = '0; flush = 1'b0;
    st_wvalid = '0; st_wdata = '0;
    rd_addr = {5'd9, 5'd8};
    rd_regfile = {RF_B, RF_A};
    #2;
    tests++; if (rd_data !== {RF_B, RF_A}) begin fails++; $display("FAIL reset_data got %h want %h", rd_data, {RF_B, RF_A}); end
    tests++; if (rd_src !== 4'd0) begin fails++; $display("FAIL reset_src got %h want 0", rd_src); end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall got %b want 0", stall); end
    #10 rst_n = 1'b1;
    step();
    #2;
    tests++; if (rd_data !== {RF_B, RF_A} || rd_src !== 4'd0) begin fails++; $display("FAIL post_reset got %h/%h want %h/0", rd_data, rd_src, {RF_B, RF_A}); end
  endtask

  task automatic test_ex_forward();
    step(); issue(5'd8);
    step(); st_wvalid = 3'b001; st_wdata[31:0] = 32'h1234;
    #2;
    tests++; if (rd_data[31:0] !== 32'h1234) begin fails++; $display("FAIL ex_fwd_data got %h want 1234", rd_data[31:0]); end
    tests++; if (rd_src[1:0] !== 2'd1 || stall !== 1'b0) begin fails++; $display("FAIL ex_fwd_src got %0d/%b want 1/0", rd_src[1:0], stall); end
    tests++; if (rd_data[63:32] !== RF_B || rd_src[3:2] !== 2'd0) begin fails++; $display("FAIL ex_fwd_port1 got %h/%0d want %h/0", rd_data[63:32], rd_src[3:2], RF_B); end
    // Late strobe on a ready entry must not overwrite the captured value.
    step(); st_wvalid = 3'b010; st_wdata[63:32] = 32'hDEAD;
    #2;
    tests++; if (rd_data[31:0] !== 32'h1234 || rd_src[1:0] !== 2'd2) begin fails++; $display("FAIL frozen got %h/%0d want 1234/2", rd_data[31:0], rd_src[1:0]); end
    step(); #2;
    tests++; if (rd_data[31:0] !== 32'h1234 || rd_src[1:0] !== 2'd3) begin fails++; $display("FAIL wb_fwd got %h/%0d want 1234/3", rd_data[31:0], rd_src[1:0]); end
    step(); #2;
    tests++; if (rd_data[31:0] !== RF_A || rd_src[1:0] !== 2'd0) begin fails++; $display("FAIL retired got %h/%0d want %h/0", rd_data[31:0], rd_src[1:0], RF_A); end
  endtask

  task automatic test_load_use();
    step(); issue(5'd8);
    step(); issue(5'd9);
    #2;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL load_use_stall got %b want 1", stall); end
    tests++; if (rd_data[31:0] !== RF_A || rd_src[1:0] !== 2'd1) begin fails++; $display("FAIL load_use_hold got %h/%0d want %h/1", rd_data[31:0], rd_src[1:0], RF_A); end
    step(); st_wvalid = 3'b010; st_wdata[63:32] = 32'h55;
    #2;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL load_use_release got %b want 0", stall); end
    tests++; if (rd_data[31:0] !== 32'h55 || rd_src[1:0] !== 2'd2) begin fails++; $display("FAIL load_use_data got %h/%0d want 55/2", rd_data[31:0], rd_src[1:0]); end
    // The issue of r9 during the stall was a bubble.
    tests++; if (rd_src[3:2] !== 2'd0 || rd_data[63:32] !== RF_B) begin fails++; $display("FAIL bubble got %0d/%h want 0/%h", rd_src[3:2], rd_data[63:32], RF_B); end
    drain();
  endtask

  task automatic test_youngest();
    step(); issue(5'd8);
    step(); st_wvalid = 3'b001; st_wdata[31:0] = 32'hBB;
    step(); issue(5'd8);
    step();
    #2;
    tests++; if (stall !== 1'b1 || rd_src[1:0] !== 2'd1) begin fails++; $display("FAIL young_pending got %b/%0d want 1/1", stall, rd_src[1:0]); end
    st_wvalid = 3'b001; st_wdata[31:0] = 32'hAA;
    #2;
    tests++; if (rd_data[31:0] !== 32'hAA || rd_src[1:0] !== 2'd1) begin fails++; $display("FAIL youngest got %h/%0d want aa/1", rd_data[31:0], rd_src[1:0]); end
    tests++; if (rd_data[63:32] !== RF_B || stall !== 1'b0) begin fails++; $display("FAIL young_port1 got %h/%b want %h/0", rd_data[63:32], stall, RF_B); end
    drain();
  endtask

  task automatic test_zero();
    step(); issue(5'd0);
    step(); rd_addr = {5'd9, 5'd0}; rd_regfile = {RF_B, 32'h77};
    st_wvalid = 3'b001; st_wdata[31:0] = 32'h99;
    #2;
    tests++; if (rd_data[31:0] !== 32'h77 || rd_src[1:0] !== 2'd0 || stall !== 1'b0) begin fails++; $display("FAIL r0 got %h/%0d/%b want 77/0/0", rd_data[31:0], rd_src[1:0], stall); end
    rd_addr = {5'd9, 5'd8}; rd_regfile = {RF_B, RF_A};
    drain();
  endtask

  task automatic test_flush_reset();
    step(); issue(5'd8);
    step(); flush = 1'b1;
    #2;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL flush_cycle_stall got %b want 1", stall); end
    step(); #2;
    tests++; if (stall !== 1'b0 || rd_src[1:0] !== 2'd0) begin fails++; $display("FAIL flushed got %b/%0d want 0/0", stall, rd_src[1:0]); end
    // Same-cycle issue is killed by flush.
    issue(5'd9); flush = 1'b1;
    step(); #2;
    tests++; if (rd_src[3:2] !== 2'd0) begin fails++; $display("FAIL flush_issue got %0d want 0", rd_src[3:2]); end
    step(); issue(5'd8);
    step(); #2;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL pre_reset_stall got %b want 1", stall); end
    rst_n = 1'b0;
    #1;
    tests++; if (stall !== 1'b0 || rd_src !== 4'd0) begin fails++; $display("FAIL async_reset got %b/%h want 0/0", stall, rd_src); end
    #2 rst_n = 1'b1;
    step(); #2;
    tests++; if (stall !== 1'b0 || rd_data !== {RF_B, RF_A}) begin fails++; $display("FAIL after_reset got %b/%h want 0/%h", stall, rd_data, {RF_B, RF_A}); end
  endtask

  initial begin
    test_reset();
    test_ex_forward();
    test_load_use();
    test_youngest();
    test_zero();
    test_flush_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
